// File: rtl/imm_pkg.sv
// Shared immediate-format codes, word payload and range-check helper.
package imm_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned ERR_CNT_W  = 8;
    localparam int unsigned SRC_W      = 3;

    typedef enum logic [SRC_W-1:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_U    = 3'b011,
        IMM_J    = 3'b100,
        IMM_JALR = 3'b101
    } imm_src_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic                  err;
    } enc_word_t;

    // True when v is the sign extension of its low 'bits' bits.
    function automatic logic fits_signed(input logic [DATA_WIDTH-1:0] v,
                                         input int unsigned bits);
        logic signed [DATA_WIDTH-1:0] t;
        t = $signed(v << (DATA_WIDTH - bits));
        t = t >>> (DATA_WIDTH - bits);
        return ($unsigned(t) == v);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate packer: scatters Imm into the format's bit
// positions of BaseInstr and flags values the format cannot represent.
module imm_pack
    import imm_pkg::*;
(
    input  logic [SRC_W-1:0]      i_imm_src,
    input  logic [DATA_WIDTH-1:0] i_imm,
    input  logic [DATA_WIDTH-1:0] i_base_instr,
    output logic [DATA_WIDTH-1:0] o_instr_c,
    output logic                  o_err_c
);

    // Field scatter and legality per format; illegal codes pass BaseInstr through.
    always_comb begin
        o_instr_c = i_base_instr;
        o_err_c   = 1'b0;
        case (i_imm_src)
            IMM_I, IMM_JALR: begin
                o_instr_c[31:20] = i_imm[11:0];
                o_err_c          = !fits_signed(i_imm, 12);
            end
            IMM_S: begin
                o_instr_c[31:25] = i_imm[11:5];
                o_instr_c[11:7]  = i_imm[4:0];
                o_err_c          = !fits_signed(i_imm, 12);
            end
            IMM_B: begin
                o_instr_c[31]    = i_imm[12];
                o_instr_c[7]     = i_imm[11];
                o_instr_c[30:25] = i_imm[10:5];
                o_instr_c[11:8]  = i_imm[4:1];
                o_err_c          = i_imm[0] || !fits_signed(i_imm, 13);
            end
            IMM_U: begin
                o_instr_c[31:12] = i_imm[31:12];
                o_err_c          = |i_imm[11:0];
            end
            IMM_J: begin
                o_instr_c[31]    = i_imm[20];
                o_instr_c[30:21] = i_imm[10:1];
                o_instr_c[20]    = i_imm[11];
                o_instr_c[19:12] = i_imm[19:12];
                o_err_c          = i_imm[0] || !fits_signed(i_imm, 21);
            end
            default: begin
                o_err_c = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder: packs requests through imm_pack into a two-entry
// output buffer with valid/ready handshakes and a saturating error counter.
module imm_encoder
    import imm_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SRC_W-1:0]      ImmSrc,
    input  logic [DATA_WIDTH-1:0] Imm,
    input  logic [DATA_WIDTH-1:0] BaseInstr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] InstrOut,
    output logic                  ImmErr,
    input  logic                  err_clr,
    output logic [ERR_CNT_W-1:0]  ErrCount
);

    // Slot 0 is the head and drives the outputs; empty slots are kept at zero.
    enc_word_t              r_slot0, r_slot1;
    logic [CNT_W-1:0]       r_count;
    logic                   r_in_ready, r_out_valid;
    logic [ERR_CNT_W-1:0]   r_err_count;

    enc_word_t              w_new, w_slot0_nxt, w_slot1_nxt;
    logic [CNT_W-1:0]       w_count_nxt;
    logic [ERR_CNT_W-1:0]   w_err_count_nxt;
    logic [DATA_WIDTH-1:0]  w_pack_instr;
    logic                   w_pack_err, w_push, w_pop;

    imm_pack u_pack (
        .i_imm_src    (ImmSrc),
        .i_imm        (Imm),
        .i_base_instr (BaseInstr),
        .o_instr_c    (w_pack_instr),
        .o_err_c      (w_pack_err)
    );

    assign w_new  = '{instr: w_pack_instr, err: w_pack_err};
    assign w_push = in_valid && r_in_ready;
    assign w_pop  = r_out_valid && out_ready;

    // Next buffer contents: pop shifts toward the head, push fills the first free slot.
    always_comb begin
        w_slot0_nxt     = r_slot0;
        w_slot1_nxt     = r_slot1;
        w_count_nxt     = r_count;
        w_err_count_nxt = r_err_count;
        if (w_pop) begin
            w_slot0_nxt = r_slot1;
            w_slot1_nxt = '0;
            w_count_nxt = r_count - CNT_W'(1);
        end
        if (w_push) begin
            if (w_count_nxt == '0) begin
                w_slot0_nxt = w_new;
            end else begin
                w_slot1_nxt = w_new;
            end
            w_count_nxt = w_count_nxt + CNT_W'(1);
        end
        if (err_clr) begin
            w_err_count_nxt = '0;
        end else if (w_pop && r_slot0.err && (r_err_count != '1)) begin
            w_err_count_nxt = r_err_count + ERR_CNT_W'(1);
        end
    end

    // State registers; handshake flags are registered from the next count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot0     <= '0;
            r_slot1     <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_slot0     <= w_slot0_nxt;
            r_slot1     <= w_slot1_nxt;
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt < CNT_W'(FIFO_DEPTH));
            r_out_valid <= (w_count_nxt != '0);
            r_err_count <= w_err_count_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign InstrOut  = r_slot0.instr;
    assign ImmErr    = r_slot0.err;
    assign ErrCount  = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed and round-trip bench for imm_encoder.
module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, ImmErr, err_clr;
    logic [2:0]  ImmSrc;
    logic [31:0] Imm, BaseInstr, InstrOut;
    logic [7:0]  ErrCount;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    imm_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ImmSrc    (ImmSrc),
        .Imm       (Imm),
        .BaseInstr (BaseInstr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .InstrOut  (InstrOut),
        .ImmErr    (ImmErr),
        .err_clr   (err_clr),
        .ErrCount  (ErrCount)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 30) $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [31:0] i, input logic [31:0] b);
        in_valid  = 1'b1;
        ImmSrc    = s;
        Imm       = i;
        BaseInstr = b;
    endtask

    // Independent reference decoder (sign-extending immediate extraction).
    function automatic logic [31:0] decode(input logic [2:0] s, input logic [31:0] x);
        case (s)
            3'b000, 3'b101: return {{20{x[31]}}, x[31:20]};
            3'b001:         return {{20{x[31]}}, x[31:25], x[11:7]};
            3'b010:         return {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
            3'b011:         return {x[31:12], 12'b0};
            default:        return {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
        endcase
    endfunction

    initial begin
        logic [31:0] r, imm_v, base_v, mask;
        logic [2:0]  s;

        vecs[0]  = '{3'b000, 32'hFFFFF800, 32'h00000013, 32'h80000013, 1'b0};
        vecs[1]  = '{3'b010, 32'h00000FFE, 32'h00000063, 32'h7E000FE3, 1'b0};
        vecs[2]  = '{3'b010, 32'h00000003, 32'h00000063, 32'h00000163, 1'b1};
        vecs[3]  = '{3'b001, 32'hFFFFFFFC, 32'h00002023, 32'hFE002E23, 1'b0};
        vecs[4]  = '{3'b011, 32'h12345000, 32'h000000B7, 32'h123450B7, 1'b0};
        vecs[5]  = '{3'b011, 32'h12345001, 32'h000000B7, 32'h123450B7, 1'b1};
        vecs[6]  = '{3'b100, 32'hFFFFFFFE, 32'h0000006F, 32'hFFFFF06F, 1'b0};
        vecs[7]  = '{3'b100, 32'h00000800, 32'h000000EF, 32'h001000EF, 1'b0};
        vecs[8]  = '{3'b100, 32'h00100000, 32'h0000006F, 32'h8000006F, 1'b1};
        vecs[9]  = '{3'b101, 32'h000007FF, 32'h000080E7, 32'h7FF080E7, 1'b0};
        vecs[10] = '{3'b101, 32'h00000800, 32'h000080E7, 32'h800080E7, 1'b1};
        vecs[11] = '{3'b110, 32'h00000123, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
        vecs[12] = '{3'b000, 32'h000007FF, 32'hFFF00093, 32'h7FF00093, 1'b0};
        vecs[13] = '{3'b001, 32'h00000000, 32'hFFFFFFFF, 32'h01FFF07F, 1'b0};
        vecs[14] = '{3'b010, 32'hFFFFF000, 32'h00000063, 32'h80000063, 1'b0};
        vecs[15] = '{3'b111, 32'h00000000, 32'h12345678, 32'h12345678, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        ImmSrc = '0; Imm = '0; BaseInstr = '0;
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_instr",     InstrOut,       32'd0);
        chk("reset_errcount",  32'(ErrCount),  32'd0);
        step(); step();
        rst = 1'b0;
        step();

        // Streamed table: one word per cycle, each visible right after its accept edge.
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            drive(vecs[i].src, vecs[i].imm, vecs[i].base);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_instr", i), InstrOut, vecs[i].exp_instr);
            chk($sformatf("vec%0d_err", i),   32'(ImmErr), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_inrdy", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("drain_valid",    32'(out_valid), 32'd0);
        chk("drain_instr",    InstrOut,       32'd0);
        chk("drain_err",      32'(ImmErr),    32'd0);
        chk("table_errcount", 32'(ErrCount),  32'd6);

        // Backpressure: three requests against a stalled consumer.
        out_ready = 1'b0;
        drive(3'b000, 32'h00000005, 32'h00000013);
        step();
        chk("bp_a_instr", InstrOut, 32'h00500013);
        chk("bp_a_inrdy", 32'(in_ready), 32'd1);
        drive(3'b011, 32'hABCDE000, 32'h00000037);
        step();
        chk("bp_full_inrdy", 32'(in_ready), 32'd0);
        chk("bp_hold_a",     InstrOut,      32'h00500013);
        drive(3'b100, 32'h00000800, 32'h000000EF);
        step();
        chk("bp_still_full", 32'(in_ready), 32'd0);
        chk("bp_hold_a2",    InstrOut,      32'h00500013);
        out_ready = 1'b1;
        step();
        chk("bp_b_instr", InstrOut,      32'hABCDE037);
        chk("bp_b_inrdy", 32'(in_ready), 32'd1);
        step();
        chk("bp_c_instr", InstrOut,       32'h001000EF);
        chk("bp_c_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset with a full buffer.
        out_ready = 1'b0;
        drive(3'b110, 32'h0, 32'hCAFEF00D);
        step();
        drive(3'b000, 32'h00000001, 32'h00000013);
        step();
        in_valid = 1'b0;
        chk("rst_pre_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_async_valid",    32'(out_valid), 32'd0);
        chk("rst_async_errcount", 32'(ErrCount),  32'd0);
        chk("rst_async_inrdy",    32'(in_ready),  32'd1);
        chk("rst_async_instr",    InstrOut,       32'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(3'b011, 32'h00001000, 32'h00000017);
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_instr", InstrOut,       32'h00001017);
        in_valid = 1'b0;
        step();
        chk("post_rst_empty", 32'(out_valid), 32'd0);

        // Round trip of random legal pairs through the reference decoder.
        for (int n = 0; n < 10000; n++) begin
            r = $urandom;
            s = 3'($urandom_range(0, 5));
            case (s)
                3'b000, 3'b101: begin imm_v = {{20{r[11]}}, r[11:0]};       mask = 32'h000FFFFF; end
                3'b001:         begin imm_v = {{20{r[11]}}, r[11:0]};       mask = 32'h01FFF07F; end
                3'b010:         begin imm_v = {{19{r[12]}}, r[12:1], 1'b0}; mask = 32'h01FFF07F; end
                3'b011:         begin imm_v = {r[31:12], 12'b0};            mask = 32'h00000FFF; end
                default:        begin imm_v = {{11{r[20]}}, r[20:1], 1'b0}; mask = 32'h00000FFF; end
            endcase
            base_v = $urandom;
            drive(s, imm_v, base_v);
            step();
            chk("rt_decode", decode(s, InstrOut), imm_v);
            chk("rt_base",   InstrOut & mask,     base_v & mask);
            chk("rt_err",    32'(ImmErr),         32'd0);
        end
        in_valid = 1'b0;
        step();

        // Saturation: 300 erroneous words, then clear coincident with an erroneous pop.
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_only", 32'(ErrCount), 32'd0);
        drive(3'b111, 32'h0, 32'h5A5A5A5A);
        repeat (300) step();
        in_valid = 1'b0;
        step();
        chk("sat_errcount", 32'(ErrCount), 32'd255);
        out_ready = 1'b0;
        drive(3'b110, 32'h0, 32'h5A5A5A5A);
        step();
        in_valid = 1'b0;
        chk("sat_hold_valid", 32'(out_valid), 32'd1);
        chk("sat_hold_count", 32'(ErrCount),  32'd255);
        out_ready = 1'b1;
        err_clr   = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_prio_count", 32'(ErrCount),  32'd0);
        chk("clr_prio_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 DATA_WIDTH, 32, instruction/immediate width; only 32 is supported.
REQ-002 FIFO_DEPTH, 2, output buffer entries; only 2 is supported.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  request can be accepted this cycle.
REQ-007 ImmSrc  input  3  immediate format: 000 I, 001 S, 010 B, 011 U, 100 jal (J), 101 jalr (I); 110/111 illegal.
REQ-008 Imm  input  32  byte-offset/value to be packed into the instruction.
REQ-009 BaseInstr  input  32  instruction with opcode/rd/rs1/rs2/funct fields set; immediate bit positions are don't-care.
REQ-010 out_valid  output  1  encoded word available.
REQ-011 out_ready  input  1  consumer takes the word this cycle.
REQ-012 InstrOut  output  32  encoded instruction.
REQ-013 ImmErr  output  1  Imm not representable in the selected format, or ImmSrc is illegal.
REQ-014 err_clr  input  1  synchronous clear of ErrCount.
REQ-015 ErrCount  output  8  saturating count of delivered words with ImmErr=1.

Function
REQ-016 Packing SHALL invert the decoder, so decode(ImmSrc, InstrOut) == Imm whenever ImmErr=0; non-immediate bits SHALL be copied from BaseInstr.
REQ-017 I/jalr: [31:20]=Imm[11:0]; legal iff Imm[31:11] are all equal.
REQ-018 S: [31:25]=Imm[11:5], [11:7]=Imm[4:0]; legal iff Imm[31:11] are all equal.
REQ-019 B: [31]=Imm[12], [7]=Imm[11], [30:25]=Imm[10:5], [11:8]=Imm[4:1]; legal iff Imm[0]=0 and Imm[31:12] are all equal.
REQ-020 U: [31:12]=Imm[31:12]; legal iff Imm[11:0]=0.
REQ-021 J: [31]=Imm[20], [30:21]=Imm[10:1], [20]=Imm[11], [19:12]=Imm[19:12]; legal iff Imm[0]=0 and Imm[31:20] are all equal.
REQ-022 Illegal ImmSrc: InstrOut=BaseInstr unmodified and ImmErr=1; for any other error, packed bits are still the truncated fields.
REQ-023 Handshake: an accept occurs when in_valid&&in_ready; a pop occurs when out_valid&&out_ready.
REQ-024 Latency: a word accepted at edge N SHALL be visible on out_valid/InstrOut/ImmErr immediately after edge N when the FIFO was empty; full throughput is one word per cycle.
REQ-025 Results SHALL be delivered in order; InstrOut/ImmErr SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 in_ready = (count < 2); it SHALL NOT depend combinationally on out_ready.
REQ-027 Push and pop at count=1 SHALL leave count at 1; a pop at count=2 SHALL make in_ready=1 the following cycle.
REQ-028 out_valid = (count != 0); InstrOut/ImmErr SHALL be 0 while count=0.
REQ-029 ErrCount SHALL increment on a pop with ImmErr=1 and saturate at 255.
REQ-030 err_clr SHALL force ErrCount to 0 at the next edge, with priority over a simultaneous increment.

Reset
REQ-031 rst SHALL immediately drive count=0, out_valid=0, in_ready=1, InstrOut=0, ImmErr=0 and ErrCount=0, irrespective of the clock.
REQ-032 Words held when rst asserts mid-operation SHALL be discarded; the first accept after rst deasserts SHALL behave as from an empty FIFO.

Structure
REQ-033 ImmSrc codes (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_JALR) SHALL live in shared package imm_pkg, also used by the sign-extension decoder.
REQ-034 Packing and legality checks SHALL be a combinational sub-module imm_pack; imm_encoder holds the FIFO, handshake and counter.

Verification
REQ-035 I: ImmSrc=000, Imm=0xFFFFF800, BaseInstr=0x00000013 -> InstrOut=0x80000013, ImmErr=0, one cycle later.
REQ-036 B: ImmSrc=010, Imm=0x00000FFE, BaseInstr=0x00000063 -> InstrOut=0x7E000FE3, ImmErr=0; Imm=0x00000003 -> ImmErr=1, ErrCount=1 after the pop.
REQ-037 Backpressure: out_ready=0 with 3 back-to-back requests -> in_ready falls after 2 accepts, outputs stay stable; releasing out_ready delivers all 3 in order.
REQ-038 Round trip: 10k random legal (ImmSrc, Imm) pairs -> decoder output equals Imm, and non-immediate bits equal BaseInstr.
REQ-039 Asynchronous rst mid-stream with count=2 -> out_valid=0 and ErrCount=0 before the next edge; the next request's result appears one cycle after its accept.
REQ-040 Saturation: 300 erroneous words -> ErrCount=255; err_clr asserted coincident with an erroneous pop -> ErrCount=0.
